mem_access_stage: RTL

//  Pipeline stage directly downstream of the execute ALU. Consumes the ALU result
//  (address or value), store data, memory-op class and funct3.

---
 rtl/common_pkg.sv | 46 ++++
 rtl/mem_access_stage_load_align.sv | 30 +++
 rtl/mem_access_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared types for the memory-access stage: memory-op class, funct3 encodings,
// FSM states and the access-size decode used by both the stage and its load aligner.
package common;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  // Any funct3 that is not a byte or halfword form falls back to a word access.
  function automatic access_size_t access_size(input logic [2:0] funct3, input logic is_store);
    access_size_t size;
    size = SZ_WORD;
    if (is_store) begin
      if (funct3 == F3_SB)      size = SZ_BYTE;
      else if (funct3 == F3_SH) size = SZ_HALF;
    end else begin
      if (funct3 == F3_LB || funct3 == F3_LBU)      size = SZ_BYTE;
      else if (funct3 == F3_LH || funct3 == F3_LHU) size = SZ_HALF;
    end
    return size;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load aligner: picks the addressed byte/halfword out of the bus word and
// sign- or zero-extends it according to funct3; unknown funct3 returns the full word.
module load_align
  import common::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{off, 3'b000} +: 8];
  assign half_lane = rdata[{off[1], 4'b0000} +: 16];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU:  data = {24'h0, byte_lane};
      F3_LH:   data = {{16{half_lane[15]}}, half_lane};
      F3_LHU:  data = {16'h0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: one outstanding load/store on a valid/ready bus,
// registered writeback slot with backpressure. Optional macro: MISALIGN_TRAP_EN.
module mem_access_stage
  import common::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_alu_out,
  input  logic [XLEN-1:0]       in_store_data,
  input  logic [1:0]            in_mem_op,
  input  logic [2:0]            in_funct3,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic [XLEN-1:0]       dmem_addr,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic                  dmem_resp_valid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_misalign
);

  mem_state_t   state, state_next;
  mem_op_t      op;
  access_size_t in_size;
  logic [1:0]   in_off;
  logic         in_is_store;
  logic         accept, is_mem, misaligned, go_mem, resp_done;
  logic [31:0]  st_wdata;
  logic [3:0]   st_wstrb;
  logic [31:0]  load_data;

  logic [1:0]            lat_off;
  logic [2:0]            lat_funct3;
  logic [REG_ADDR_W-1:0] lat_rd;
  logic                  lat_store;

  assign op          = mem_op_t'(in_mem_op);
  assign in_off      = in_alu_out[1:0];
  assign in_is_store = (op == MEM_STORE);
  assign in_size     = access_size(in_funct3, in_is_store);

  assign in_ready  = (state == IDLE) && (!wb_valid || wb_ready);
  assign accept    = in_valid && in_ready;
  assign is_mem    = (op == MEM_LOAD) || (op == MEM_STORE);
  assign resp_done = (state == RESP) && dmem_resp_valid;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = is_mem && ((in_size == SZ_HALF && in_off[0]) ||
                                 (in_size == SZ_WORD && in_off != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign go_mem = accept && is_mem && !misaligned;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go_mem) state_next = REQ;
      REQ:     if (dmem_req_ready) state_next = RESP;
      RESP:    if (dmem_resp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane replication lets the bus write the addressed lanes without its own shifter.
  always_comb begin
    st_wdata = in_store_data;
    st_wstrb = 4'b1111;
    case (in_size)
      SZ_BYTE: begin
        st_wdata = {4{in_store_data[7:0]}};
        st_wstrb = 4'b0001 << in_off;
      end
      SZ_HALF: begin
        st_wdata = {2{in_store_data[15:0]}};
        st_wstrb = 4'b0011 << {in_off[1], 1'b0};
      end
      default: begin
        st_wdata = in_store_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_req_valid <= 1'b0;
      dmem_addr      <= '0;
      dmem_we        <= 1'b0;
      dmem_wdata     <= '0;
      dmem_wstrb     <= 4'b0000;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      wb_misalign    <= 1'b0;
    end else begin
      if (wb_valid && wb_ready) wb_valid <= 1'b0;

      // Pass-through ops and trapped misaligned accesses complete straight from IDLE.
      if (accept && !go_mem) begin
        wb_valid    <= 1'b1;
        wb_misalign <= misaligned;
        wb_rd       <= misaligned ? '0 : in_rd;
        wb_data     <= in_alu_out;
      end

      if (go_mem) begin
        dmem_req_valid <= 1'b1;
        dmem_addr      <= {in_alu_out[XLEN-1:2], 2'b00};
        dmem_we        <= in_is_store;
        dmem_wdata     <= in_is_store ? st_wdata : '0;
        dmem_wstrb     <= in_is_store ? st_wstrb : 4'b0000;
      end

      if (state == REQ && dmem_req_ready) dmem_req_valid <= 1'b0;

      if (resp_done) begin
        wb_valid    <= 1'b1;
        wb_misalign <= 1'b0;
        wb_rd       <= lat_store ? '0 : lat_rd;
        wb_data     <= lat_store ? '0 : load_data;
      end
    end
  end

  // NOTE: payload registers carry no reset; they are only read while state says they are live.
  always_ff @(posedge clk) begin
    if (go_mem) begin
      lat_off    <= in_off;
      lat_funct3 <= in_funct3;
      lat_rd     <= in_rd;
      lat_store  <= in_is_store;
    end
  end

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .off    (lat_off),
    .funct3 (lat_funct3),
    .data   (load_data)
  );

endmodule
